// File: rtl/byte_seq_source_if.sv
// Valid/ready byte stream from the sequence source to its consumer, with beat index and wrap marker.
interface byte_seq_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             ready;
  logic [3:0]       idx;
  logic             wrap;

  modport master (output out_data, out_valid, idx, wrap, input ready);
  modport slave  (input out_data, out_valid, idx, wrap, output ready);
endinterface

// File: rtl/byte_seq_source.sv
// Arithmetic byte source STEP..COUNT*STEP over valid/ready; first beat 1 cycle after start,
// all outputs registered, beat held stable while ready is low, one beat per cycle when ready stays high.
module byte_seq_source #(
  parameter int WIDTH = 8,
  parameter int STEP  = 11,
  parameter int COUNT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  output logic                busy,
  output logic [7:0]          total,
  byte_seq_source_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [3:0]       LAST   = 4'(COUNT - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [3:0]       idx_q, idx_n;
  logic             valid_q, valid_n;
  logic             wrap_q, wrap_n;
  logic [7:0]       total_q, total_n;
  logic             mode_q, mode_n;
  logic             accept;
  logic             last;
  logic [7:0]       total_inc;

  assign accept    = valid_q & bus.ready;
  assign last      = (idx_q == LAST);
  assign total_inc = (total_q == 8'hFF) ? total_q : total_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      total_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      wrap_q  <= wrap_n;
      total_q <= total_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    wrap_n  = 1'b0;
    total_n = total_q;
    mode_n  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          data_n  = STEP_V;
          idx_n   = '0;
          valid_n = 1'b1;
          mode_n  = mode;
        end
      end
      RUN: begin
        if (accept) begin
          total_n = total_inc;
          wrap_n  = last;
          // A stop that coincides with an accept ends the pass right here, beat values frozen.
          if (stop) begin
            valid_n = 1'b0;
            state_n = IDLE;
          end else if (last) begin
            if (mode_q) begin
              valid_n = 1'b0;
              state_n = IDLE;
            end else begin
              idx_n  = '0;
              data_n = STEP_V;
            end
          end else begin
            idx_n  = idx_q + 4'd1;
            data_n = data_q + STEP_V;
          end
        end else if (stop) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          total_n = total_inc;
          wrap_n  = last;
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
  assign busy          = (state != IDLE);
  assign total         = total_q;

endmodule
